// File: rtl/console_uart_tx.sv
// Console UART back end: snoops CHAR_OUT writes into a FIFO and shifts them out as 8N1 frames.
// Write-to-start-bit latency is 2 edges; writes to a full FIFO are dropped and flagged as overflow.

module console_uart_tx_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               dat_i,
  output logic [W-1:0]               dat_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  // Generic FIFO, first-word fall-through, head visible on dat_o.
  // Caller guarantees no push when full and no pop when empty.
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dat_o   = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

module console_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        full_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          ovf_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;

  logic [CW-1:0] count;
  logic [7:0]    head;
  logic          empty;
  logic          wr_char;
  logic          wr_ctrl;
  logic          rd_req;
  logic          push;
  logic          pop;
  logic          baud_last;

  assign wr_char   = req_i & we_i & (addr_i[7:0] == 8'h04);
  assign wr_ctrl   = req_i & we_i & (addr_i[7:0] == 8'h0C);
  assign rd_req    = req_i & ~we_i;
  assign empty     = (count == '0);
  assign full_o    = (count == CW'(FIFO_DEPTH));
  assign busy_o    = (state_q != IDLE) | ~empty;
  assign push      = wr_char & ~full_o;
  assign baud_last = (baud_q == 16'(CLK_DIV - 1));
  // A new frame is loaded from IDLE or on the final stop-bit cycle, giving gapless back-to-back frames.
  assign pop       = ~empty & ((state_q == IDLE) | ((state_q == STOP) & baud_last));

  console_uart_tx_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .dat_i   (wdata_i[7:0]),
    .dat_o   (head),
    .count_o (count)
  );

  always_comb begin
    rdata_d = '0;
    if (addr_i[7:0] == 8'h00) begin
      rdata_d = {16'h0000, 8'(count), 4'h0, ovf_q, busy_o, full_o, empty};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (rd_req) rdata_q <= rdata_d;
      if (wr_char & full_o)          ovf_q <= 1'b1;
      else if (wr_ctrl & wdata_i[0]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= head;
              bit_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_o    = tx_q;
  assign rdata_o = rdata_q;
endmodule
